// File: rtl/subtractor_if.sv
// rtl/subtractor_if.sv - operand-pair and result handshake bundle for subtractor.
interface subtractor_if #(parameter int width_p = 32);
  logic               valid_i;
  logic               ready_o;
  logic [width_p:0]   c_i;
  logic [width_p-1:0] a_i;
  logic               valid_o;
  logic               ready_i;
  logic [width_p-1:0] b_o;
  logic               err_o;

  modport slave (
    input  valid_i, c_i, a_i, ready_i,
    output ready_o, valid_o, b_o, err_o
  );

  modport master (
    output valid_i, c_i, a_i, ready_i,
    input  ready_o, valid_o, b_o, err_o
  );
endinterface

// File: rtl/subtractor.sv
// rtl/subtractor.sv - two-stage valid/ready pipeline recovering b = c - a from a width_p+1-bit sum.
// Define SUBTRACTOR_DSP_EN to map the stage-2 subtraction onto a DSP48E1 instead of fabric.
module subtractor #(
  parameter int width_p = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  subtractor_if.slave  bus
);
  localparam int dw_lp = width_p + 2;

  logic               v1, v2;
  logic               en1, en2;
  logic [width_p:0]   c1;
  logic [width_p-1:0] a1;
  logic [dw_lp-1:0]   d;
  logic [width_p-1:0] b2;
  logic               err2;

  // Each stage advances when it is empty or its consumer is taking its content.
  assign en2 = ~v2 | bus.ready_i;
  assign en1 = ~v1 | en2;

  assign bus.ready_o = en1;
  assign bus.valid_o = v2;
  assign bus.b_o     = b2;
  assign bus.err_o   = err2;

`ifdef SUBTRACTOR_DSP_EN
  logic [47:0] ab_w;
  logic [47:0] cc_w;
  logic [47:0] p_w;

  assign ab_w = 48'(a1);
  assign cc_w = 48'(c1);

  // OPMODE selects Z=C, Y=0, X=A:B; ALUMODE 0011 gives P = Z - X.
  DSP48E1 #(
    .USE_MULT      ("NONE"),
    .USE_SIMD      ("ONE48"),
    .USE_DPORT     ("FALSE"),
    .AREG          (0),
    .BREG          (0),
    .ACASCREG      (0),
    .BCASCREG      (0),
    .CREG          (0),
    .DREG          (0),
    .ADREG         (0),
    .MREG          (0),
    .PREG          (0),
    .ALUMODEREG    (0),
    .OPMODEREG     (0),
    .INMODEREG     (0),
    .CARRYINREG    (0),
    .CARRYINSELREG (0)
  ) dsp_i (
    .CLK           (clk_i),
    .A             (ab_w[47:18]),
    .B             (ab_w[17:0]),
    .C             (cc_w),
    .D             (25'd0),
    .OPMODE        (7'b0110011),
    .ALUMODE       (4'b0011),
    .INMODE        (5'b00000),
    .CARRYIN       (1'b0),
    .CARRYINSEL    (3'b000),
    .CEA1          (1'b0),
    .CEA2          (1'b0),
    .CEB1          (1'b0),
    .CEB2          (1'b0),
    .CEC           (1'b0),
    .CED           (1'b0),
    .CEAD          (1'b0),
    .CEM           (1'b0),
    .CEP           (1'b0),
    .CEALUMODE     (1'b0),
    .CECTRL        (1'b0),
    .CEINMODE      (1'b0),
    .CECARRYIN     (1'b0),
    .RSTA          (1'b0),
    .RSTB          (1'b0),
    .RSTC          (1'b0),
    .RSTD          (1'b0),
    .RSTM          (1'b0),
    .RSTP          (1'b0),
    .RSTALLCARRYIN (1'b0),
    .RSTALUMODE    (1'b0),
    .RSTCTRL       (1'b0),
    .RSTINMODE     (1'b0),
    .P             (p_w)
  );

  assign d = p_w[dw_lp-1:0];
`else
  assign d = {1'b0, c1} - {2'b00, a1};
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      c1   <= '0;
      a1   <= '0;
      b2   <= '0;
      err2 <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= bus.valid_i;
        if (bus.valid_i) begin
          c1 <= bus.c_i;
          a1 <= bus.a_i;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          b2   <= d[width_p-1:0];
          // Any bit above width_p means the difference went negative or overflowed.
          err2 <= |d[dw_lp-1:width_p];
        end
      end
    end
  end
endmodule

// File: tb/tb_subtractor.sv
// tb/tb_subtractor.sv - self-checking bench for subtractor against an arithmetic reference model.
module tb_subtractor;
  localparam int W = 32;

  logic clk_i = 1'b0;
  logic reset_i;

  always #5 clk_i = ~clk_i;

  subtractor_if #(.width_p(W)) bus ();

  subtractor #(.width_p(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  // Reference: exact integer difference, low W bits plus out-of-range flag.
  function automatic logic [W:0] model(input logic [W:0] c, input logic [W-1:0] a);
    longint diff;
    longint lim;
    logic   err;
    diff = longint'(c) - longint'(a);
    lim  = longint'(1) << W;
    err  = (diff < 0) || (diff >= lim);
    return {err, diff[W-1:0]};
  endfunction

  task automatic drive(input logic v, input logic [W:0] c, input logic [W-1:0] a);
    bus.valid_i = v;
    bus.c_i     = c;
    bus.a_i     = a;
  endtask

  task automatic rand_pair(output logic [W:0] c, output logic [W-1:0] a);
    c[W]     = 1'($urandom_range(0, 1));
    c[W-1:0] = $urandom();
    a        = $urandom();
  endtask

  task automatic test_reset;
    reset_i     = 1'b1;
    bus.ready_i = 1'b1;
    drive(1'b1, 33'd5, 32'd3);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready_o); end
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    checks++;
    if (bus.b_o !== 32'h0) begin errors++; $display("FAIL reset_b: got %h want 0", bus.b_o); end
    checks++;
    if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
    drive(1'b0, '0, '0);
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_no_transfer: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_vectors;
    logic [W:0]   vc[3];
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic         ve[3];
    logic [W:0]   m;
    vc[0] = 33'h1_0000_0005; va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0006; ve[0] = 1'b0;
    vc[1] = 33'd5;           va[1] = 32'd7;         vb[1] = 32'hFFFF_FFFE; ve[1] = 1'b1;
    vc[2] = 33'h1_0000_0000; va[2] = 32'd0;         vb[2] = 32'h0;         ve[2] = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vc[i], va[i]);
      @(negedge clk_i);
      drive(1'b0, '0, '0);
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL vec%0d_early: got valid %b want 0", i, bus.valid_o); end
      @(negedge clk_i);
      checks++;
      if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL vec%0d_latency: got valid %b want 1", i, bus.valid_o); end
      checks++;
      if (bus.b_o !== vb[i] || bus.err_o !== ve[i])
        begin errors++; $display("FAIL vec%0d_value: got b %h err %b want b %h err %b", i, bus.b_o, bus.err_o, vb[i], ve[i]); end
      m = model(vc[i], va[i]);
      checks++;
      if ({bus.err_o, bus.b_o} !== m) begin errors++; $display("FAIL vec%0d_model: got %h want %h", i, {bus.err_o, bus.b_o}, m); end
      @(negedge clk_i);
      checks++;
      if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL vec%0d_drain: got valid %b want 0", i, bus.valid_o); end
    end
  endtask

  task automatic test_stream;
    logic [W:0]   c;
    logic [W-1:0] a;
    logic [W:0]   e;
    exp_q.delete();
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 102; cyc++) begin
      checks++;
      if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d: got %b want 1", cyc, bus.ready_o); end
      checks++;
      if (bus.valid_o !== (cyc >= 2)) begin errors++; $display("FAIL stream_valid c%0d: got %b want %b", cyc, bus.valid_o, cyc >= 2); end
      if (bus.valid_o === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra c%0d: got unexpected result %h want none", cyc, bus.b_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus.err_o, bus.b_o} !== e) begin errors++; $display("FAIL stream_data c%0d: got %h want %h", cyc, {bus.err_o, bus.b_o}, e); end
        end
      end
      if (cyc < 100) begin
        rand_pair(c, a);
        drive(1'b1, c, a);
        exp_q.push_back(model(c, a));
      end else begin
        drive(1'b0, '0, '0);
      end
      @(negedge clk_i);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stream_missing: got %0d left want 0", exp_q.size()); end
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL stream_end: got valid %b want 0", bus.valid_o); end
  endtask

  task automatic test_backpressure;
    logic [W:0]   pc[3];
    logic [W-1:0] pa[3];
    for (int i = 0; i < 3; i++) rand_pair(pc[i], pa[i]);
    bus.ready_i = 1'b0;
    drive(1'b1, pc[0], pa[0]);
    @(negedge clk_i);
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_accept1: got ready %b want 1", bus.ready_o); end
    drive(1'b1, pc[1], pa[1]);
    @(negedge clk_i);
    drive(1'b1, pc[2], pa[2]);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready k%0d: got %b want 0", k, bus.ready_o); end
      checks++;
      if (bus.valid_o !== 1'b1 || {bus.err_o, bus.b_o} !== model(pc[0], pa[0]))
        begin errors++; $display("FAIL bp_hold k%0d: got v %b %h want v 1 %h", k, bus.valid_o, {bus.err_o, bus.b_o}, model(pc[0], pa[0])); end
      @(negedge clk_i);
    end
    bus.ready_i = 1'b1;
    #1;
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.ready_o); end
    @(negedge clk_i);
    drive(1'b0, '0, '0);
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (bus.valid_o !== 1'b1 || {bus.err_o, bus.b_o} !== model(pc[k], pa[k]))
        begin errors++; $display("FAIL bp_order p%0d: got v %b %h want v 1 %h", k, bus.valid_o, {bus.err_o, bus.b_o}, model(pc[k], pa[k])); end
      @(negedge clk_i);
    end
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid %b want 0", bus.valid_o); end
  endtask

  task automatic test_reset_mid;
    logic [W:0]   pc[3];
    logic [W-1:0] pa[3];
    for (int i = 0; i < 3; i++) rand_pair(pc[i], pa[i]);
    pa[0] = 32'd1;
    pc[0] = 33'h0_8000_0000;
    bus.ready_i = 1'b0;
    drive(1'b1, pc[0], pa[0]);
    @(negedge clk_i);
    drive(1'b1, pc[1], pa[1]);
    @(negedge clk_i);
    drive(1'b0, '0, '0);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0)
      begin errors++; $display("FAIL rm_full: got v %b r %b want v 1 r 0", bus.valid_o, bus.ready_o); end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.b_o !== 32'h0 || bus.err_o !== 1'b0)
      begin errors++; $display("FAIL rm_async_clear: got v %b b %h e %b want 0 0 0", bus.valid_o, bus.b_o, bus.err_o); end
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", bus.ready_o); end
    @(negedge clk_i);
    reset_i     = 1'b0;
    bus.ready_i = 1'b1;
    drive(1'b1, pc[2], pa[2]);
    @(negedge clk_i);
    drive(1'b0, '0, '0);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rm_early: got valid %b want 0", bus.valid_o); end
    @(negedge clk_i);
    checks++;
    if (bus.valid_o !== 1'b1 || {bus.err_o, bus.b_o} !== model(pc[2], pa[2]))
      begin errors++; $display("FAIL rm_first: got v %b %h want v 1 %h", bus.valid_o, {bus.err_o, bus.b_o}, model(pc[2], pa[2])); end
    @(negedge clk_i);
    checks++;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rm_discard: got valid %b want 0", bus.valid_o); end
  endtask

  initial begin
    drive(1'b0, '0, '0);
    bus.ready_i = 1'b0;
    reset_i     = 1'b1;
    test_reset;
    test_vectors;
    test_stream;
    test_backpressure;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
